// File: rtl/mfe_pkg.sv
// Purpose: shared constants for the 3x3 rank-filter engine (FSM states, mode and
//          padding encodings, rank indices into the sorted tap vector).
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mfe_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOADF = 3'd1;  // full 9-tap window load
    localparam logic [2:0] ST_LOADC = 3'd2;  // 3-tap right-column load
    localparam logic [2:0] ST_SORT  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Filter mode encodings; 2'b11 is reserved and behaves as median
    localparam logic [1:0] MODE_MED = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;

    // Border handling encodings
    localparam logic PAD_ZERO = 1'b0;
    localparam logic PAD_EDGE = 1'b1;

    // Positions in the ascending sorted window
    localparam int IDX_MIN = 0;
    localparam int IDX_MED = 4;
    localparam int IDX_MAX = 8;

    localparam int NTAPS = 9;

    // Which sorted entry the requested mode reads out.
    function automatic logic [3:0] rank_index(input logic [1:0] m);
        case (m)
            MODE_MIN: return 4'(IDX_MIN);
            MODE_MAX: return 4'(IDX_MAX);
            default:  return 4'(IDX_MED);
        endcase
    endfunction

endpackage

// File: rtl/mfe_param_oe_sort9.sv
// Purpose: registered 9-entry odd-even transposition sorter, ascending order.
//          Ports: load captures din and clears the layer counter; step applies one
//          compare-exchange layer (parity from the counter); dout is the buffer.
// Latency: 9 step cycles after load give a fully sorted dout.
// Backpressure: none; the caller sequences load/step.
module oe_sort9 #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [8:0][DW-1:0] din,
    output logic [8:0][DW-1:0] dout
);

    logic [8:0][DW-1:0] sbuf;
    logic [8:0][DW-1:0] layer;
    logic [3:0]         lcnt;

    // One layer: even layers pair (0,1),(2,3),(4,5),(6,7); odd layers pair
    // (1,2),(3,4),(5,6),(7,8). Strict '>' leaves equal neighbours untouched.
    always_comb begin
        layer = sbuf;
        for (int i = 0; i < 8; i++) begin
            if (1'(i) == lcnt[0]) begin
                if (sbuf[i] > sbuf[i+1]) begin
                    layer[i]   = sbuf[i+1];
                    layer[i+1] = sbuf[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sbuf <= '0;
            lcnt <= '0;
        end else if (load) begin
            sbuf <= din;
            lcnt <= '0;
        end else if (step) begin
            sbuf <= layer;
            lcnt <= lcnt + 4'd1;
        end
    end

    assign dout = sbuf;

endmodule

// File: rtl/mfe_param.sv
// Purpose: 3x3 min/median/max filter, ROM in -> RAM out, with zero or edge padding.
//          Ports: ready starts a frame; mode/pad_mode latched at start; iaddr/idata
//          ROM read; addr/data_wr/wen RAM write; busy during frame, done pulse.
// Latency: 19 cycles for x=0 pixels, 13 otherwise; one DONE cycle per frame.
// Backpressure: none; ROM is combinational and RAM always accepts a write.
module mfe_param
    import mfe_pkg::*;
#(
    parameter  int IMG_W = 128,
    parameter  int IMG_H = 128,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic [1:0]    mode,
    input  logic          pad_mode,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_wr,
    output logic          wen
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]         state;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [AW-1:0]      ybase;      // y * IMG_W, kept incrementally
    logic [1:0]         tr;         // window row of the tap being fetched
    logic [1:0]         tc;         // window column of the tap being fetched
    logic [3:0]         scnt;       // sort layer counter
    logic [1:0]         mode_q;
    logic               pad_q;
    logic [8:0][DW-1:0] win;        // window, tap index = 3*row + col

    // ------------------------------------------------------------------
    // Tap address and border handling
    // ------------------------------------------------------------------
    logic               in_load;
    logic               row_lo, row_hi, col_lo, col_hi, oob;
    logic [AW-1:0]      tap_row_base;
    logic [AW-1:0]      tap_col;
    logic [DW-1:0]      tap_val;
    logic [3:0]         tap_idx;
    logic               last_tap;
    logic [8:0][DW-1:0] win_nxt;
    logic [8:0][DW-1:0] sorted;

    assign in_load = (state == ST_LOADF) || (state == ST_LOADC);

    // A tap falls outside the image only on the first/last row or column.
    assign row_lo = (tr == 2'd0) && (y == '0);
    assign row_hi = (tr == 2'd2) && (y == Y_LAST);
    assign col_lo = (tc == 2'd0) && (x == '0);
    assign col_hi = (tc == 2'd2) && (x == X_LAST);
    assign oob    = row_lo || row_hi || col_lo || col_hi;

    // The clamped coordinate is used for the address in both padding modes,
    // so no subtraction ever goes below zero and no sum passes the last pixel.
    always_comb begin
        case (tr)
            2'd0:    tap_row_base = row_lo ? ybase : ybase - ROW_STEP;
            2'd2:    tap_row_base = row_hi ? ybase : ybase + ROW_STEP;
            default: tap_row_base = ybase;
        endcase
        case (tc)
            2'd0:    tap_col = col_lo ? AW'(x) : AW'(x) - AW'(1);
            2'd2:    tap_col = col_hi ? AW'(x) : AW'(x) + AW'(1);
            default: tap_col = AW'(x);
        endcase
    end

    assign iaddr   = in_load ? (tap_row_base + tap_col) : '0;
    assign tap_val = (oob && (pad_q == PAD_ZERO)) ? '0 : idata;
    assign tap_idx = {2'b00, tr} + {2'b00, tr} + {2'b00, tr} + {2'b00, tc};

    // The sorter is loaded on the final fetch cycle, so it must see the
    // window including the tap being written in that same cycle.
    assign last_tap = in_load && (tr == 2'd2) && (tc == 2'd2);

    always_comb begin
        win_nxt = win;
        if (in_load) begin
            win_nxt[tap_idx] = tap_val;
        end
    end

    oe_sort9 #(.DW(DW)) u_sort (
        .clk   (clk),
        .reset (reset),
        .load  (last_tap),
        .step  (state == ST_SORT),
        .din   (win_nxt),
        .dout  (sorted)
    );

    // ------------------------------------------------------------------
    // Outputs: decoded from state so reset clears them immediately
    // ------------------------------------------------------------------
    assign busy    = (state == ST_LOADF) || (state == ST_LOADC) ||
                     (state == ST_SORT)  || (state == ST_WRITE);
    assign done    = (state == ST_DONE);
    assign wen     = (state == ST_WRITE);
    assign addr    = wen ? (ybase + AW'(x)) : '0;
    assign data_wr = wen ? sorted[rank_index(mode_q)] : '0;

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            x      <= '0;
            y      <= '0;
            ybase  <= '0;
            tr     <= '0;
            tc     <= '0;
            scnt   <= '0;
            mode_q <= MODE_MED;
            pad_q  <= PAD_ZERO;
            win    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready) begin
                        mode_q <= mode;
                        pad_q  <= pad_mode;
                        x      <= '0;
                        y      <= '0;
                        ybase  <= '0;
                        tr     <= '0;
                        tc     <= '0;
                        state  <= ST_LOADF;
                    end
                end

                // Raster order over the window: column fastest.
                ST_LOADF: begin
                    win <= win_nxt;
                    if (tc == 2'd2) begin
                        tc <= '0;
                        if (tr == 2'd2) begin
                            tr    <= '0;
                            scnt  <= '0;
                            state <= ST_SORT;
                        end else begin
                            tr <= tr + 2'd1;
                        end
                    end else begin
                        tc <= tc + 2'd1;
                    end
                end

                // Only the right-hand column (tc fixed at 2) is fetched.
                ST_LOADC: begin
                    win <= win_nxt;
                    if (tr == 2'd2) begin
                        tr    <= '0;
                        scnt  <= '0;
                        state <= ST_SORT;
                    end else begin
                        tr <= tr + 2'd1;
                    end
                end

                ST_SORT: begin
                    scnt <= scnt + 4'd1;
                    if (scnt == 4'(NTAPS - 1)) begin
                        state <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    tr <= '0;
                    if (x == X_LAST) begin
                        x  <= '0;
                        tc <= '0;
                        if (y == Y_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            y     <= y + YW'(1);
                            ybase <= ybase + ROW_STEP;
                            state <= ST_LOADF;
                        end
                    end else begin
                        x  <= x + XW'(1);
                        tc <= 2'd2;
                        // Slide left; the right column is refilled by LOADC.
                        for (int r = 0; r < 3; r++) begin
                            win[3*r]   <= win[3*r+1];
                            win[3*r+1] <= win[3*r+2];
                        end
                        state <= ST_LOADC;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfe_param.sv
// Purpose: self-checking bench for mfe_param on an 8x8 image with a behavioural
//          neighbourhood-sort reference model, pattern tables and reset/restart cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_mfe_param;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int FRAME_BUSY = H * (19 + 13 * (W - 1));

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic [1:0] mode;
    logic       pad_mode;
    logic       busy;
    logic       done;
    logic [5:0] iaddr;
    logic [7:0] idata;
    logic [5:0] addr;
    logic [7:0] data_wr;
    logic       wen;

    logic [7:0] img [0:N-1];
    logic [7:0] res [0:N-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign idata = img[iaddr];

    mfe_param #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .mode     (mode),
        .pad_mode (pad_mode),
        .busy     (busy),
        .done     (done),
        .iaddr    (iaddr),
        .idata    (idata),
        .addr     (addr),
        .data_wr  (data_wr),
        .wen      (wen)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Gather the 3x3 neighbourhood, sort it, pick the rank for the mode.
    function automatic int ref_pix(input int px, input int py,
                                   input logic [1:0] m, input logic p);
        int v[9];
        int n;
        int t;
        int xx;
        int yy;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                xx = px + dx;
                yy = py + dy;
                if (xx >= 0 && xx < W && yy >= 0 && yy < H) begin
                    v[n] = int'(img[yy*W + xx]);
                end else if (p) begin
                    if (xx < 0) xx = 0;
                    if (xx > W - 1) xx = W - 1;
                    if (yy < 0) yy = 0;
                    if (yy > H - 1) yy = H - 1;
                    v[n] = int'(img[yy*W + xx]);
                end else begin
                    v[n] = 0;
                end
                n++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        case (m)
            2'b01:   return v[0];
            2'b10:   return v[8];
            default: return v[4];
        endcase
    endfunction

    // 0 const 0x55, 1 ramp, 2 impulse, 3 random, 4 random with many ties
    task automatic fill_image(input int pat);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0:       img[i] = 8'h55;
                1:       img[i] = 8'((i % W) + (i / W));
                2:       img[i] = (i == 3*W + 3) ? 8'hFF : 8'h00;
                3:       img[i] = 8'($urandom_range(0, 255));
                default: img[i] = 8'($urandom_range(0, 3) * 40);
            endcase
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input logic p, input bit tog);
        int  nwr;
        int  bcyc;
        int  cyc;
        int  stray;
        bit  gd;
        @(negedge clk);
        mode     = m;
        pad_mode = p;
        ready    = 1'b1;
        @(negedge clk);
        chk("busy_rise", int'(busy), 1);
        if (!tog) ready = 1'b0;
        // Scramble the inputs to confirm they were latched at start.
        mode     = 2'($urandom);
        pad_mode = 1'($urandom);
        nwr = 0; bcyc = 0; cyc = 0; stray = 0; gd = 1'b0;
        while (!gd && cyc < 3000) begin
            if (busy) bcyc++;
            if (wen) begin
                chk("wr_addr", int'(addr), nwr);
                if (nwr < N) begin
                    res[nwr] = data_wr;
                    chk("wr_data", int'(data_wr), ref_pix(nwr % W, nwr / W, m, p));
                end
                nwr++;
            end else if (addr != '0 || data_wr != '0) begin
                stray++;
            end
            if (done) begin
                gd = 1'b1;
            end else begin
                if (tog) ready = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        ready = 1'b0;
        chk("done_seen", int'(gd), 1);
        chk("num_writes", nwr, N);
        chk("busy_cycles", bcyc, FRAME_BUSY);
        chk("outputs_zero_off_write", stray, 0);
        chk("busy_in_done", int'(busy), 0);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        @(negedge clk);
        chk("no_restart", int'(busy), 0);
    endtask

    typedef struct {
        int         pat;
        logic [1:0] m;
        logic       p;
        bit         tog;
        bit         hc;    // e00/e44 are meaningful
        int         e00;   // expected result at (0,0)
        int         e44;   // expected result at (4,4)
    } vec_t;

    vec_t tbl [9];

    initial begin
        int errs;
        int cyc;
        int nwr;
        int e;

        tbl[0] = '{0, 2'b00, 1'b0, 1'b0, 1'b1, 0,    8'h55};
        tbl[1] = '{0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h55, 8'h55};
        tbl[2] = '{1, 2'b01, 1'b1, 1'b0, 1'b1, 0,    6};
        tbl[3] = '{2, 2'b10, 1'b0, 1'b0, 1'b1, 0,    8'hFF};
        tbl[4] = '{2, 2'b00, 1'b0, 1'b0, 1'b1, 0,    0};
        tbl[5] = '{4, 2'b11, 1'b0, 1'b1, 1'b0, 0,    0};
        tbl[6] = '{3, 2'b01, 1'b0, 1'b0, 1'b0, 0,    0};
        tbl[7] = '{3, 2'b10, 1'b1, 1'b0, 1'b0, 0,    0};
        tbl[8] = '{3, 2'b00, 1'b1, 1'b0, 1'b0, 0,    0};

        reset    = 1'b1;
        ready    = 1'b0;
        mode     = 2'b00;
        pad_mode = 1'b0;
        fill_image(0);
        #12;
        chk("rst_busy",    int'(busy),    0);
        chk("rst_done",    int'(done),    0);
        chk("rst_wen",     int'(wen),     0);
        chk("rst_iaddr",   int'(iaddr),   0);
        chk("rst_addr",    int'(addr),    0);
        chk("rst_data_wr", int'(data_wr), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int t = 0; t < 9; t++) begin
            fill_image(tbl[t].pat);
            run_frame(tbl[t].m, tbl[t].p, tbl[t].tog);
            if (tbl[t].hc) begin
                chk("tbl_e00", int'(res[0]),       tbl[t].e00);
                chk("tbl_e44", int'(res[4*W + 4]), tbl[t].e44);
            end
            errs = 0;
            for (int yy = 0; yy < H; yy++) begin
                for (int xx = 0; xx < W; xx++) begin
                    e = -1;
                    if (tbl[t].pat == 0 && tbl[t].p == 1'b0)
                        e = ((xx == 0 || xx == W-1) && (yy == 0 || yy == H-1)) ? 0 : 8'h55;
                    else if (tbl[t].pat == 0)
                        e = 8'h55;
                    else if (tbl[t].pat == 1)
                        e = (xx > 0 ? xx - 1 : 0) + (yy > 0 ? yy - 1 : 0);
                    else if (tbl[t].pat == 2 && tbl[t].m == 2'b10)
                        e = (xx >= 2 && xx <= 4 && yy >= 2 && yy <= 4) ? 8'hFF : 0;
                    else if (tbl[t].pat == 2)
                        e = 0;
                    if (e >= 0 && int'(res[yy*W + xx]) != e) errs++;
                end
            end
            if (tbl[t].hc) chk("pattern_rule", errs, 0);
        end

        // Reset while pixel 20 is in SORT, then restart from address 0.
        fill_image(3);
        @(negedge clk);
        mode = 2'b00; pad_mode = 1'b1; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        nwr = 0; cyc = 0;
        while (nwr < 20 && cyc < 3000) begin
            if (wen) nwr++;
            if (nwr < 20) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("reach_pixel20", nwr, 20);
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_wen",  int'(wen),  0);
        chk("mid_rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        errs = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || wen || done) errs++;
        end
        chk("post_rst_quiet", errs, 0);
        run_frame(2'b00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfe_param.md
# mfe_param

Parametrised 3×3 rank-filter engine, the next generation of the team's median filter engine. Streams a greyscale image from the input ROM port, computes a per-pixel min, median or max over the 3×3 neighbourhood with selectable border handling, and writes each result to the output RAM port. It reuses the window horizontally, so only the new right-hand column is fetched within a row. It sits between the image ROM and the result RAM, and the testbench or host starts it with `ready`.

## Interface
- `IMG_W`, default 128: image width in pixels, ≥ 2.
- `IMG_H`, default 128: image height in pixels, ≥ 2.
- `DW`, default 8: pixel width in bits.
- `AW` (localparam): `$clog2(IMG_W*IMG_H)`, the address width.
- `clk` in, 1 bit: the single clock; all state updates on its rising edge.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `ready` in, 1 bit: start request, sampled only in IDLE.
- `mode` in, 2 bits: 00 median, 01 min, 10 max, 11 reserved and treated as median. Latched at start.
- `pad_mode` in, 1 bit: 0 zero padding, 1 edge replication. Latched at start.
- `busy` out, 1 bit: high while a frame is in progress.
- `done` out, 1 bit: one-cycle pulse after the last write.
- `iaddr` out, AW bits: ROM read address.
- `idata` in, DW bits: ROM data, combinational from `iaddr` and valid in the same cycle.
- `addr` out, AW bits: RAM write address.
- `data_wr` out, DW bits: RAM write data.
- `wen` out, 1 bit: RAM write enable.

## Operation
- **FSM states:** IDLE, LOADF (full load of 9 taps), LOADC (column load of 3 taps), SORT, WRITE, DONE.
- **IDLE:**
  - `ready`=1 → latch `mode`/`pad_mode`, set (x,y)=(0,0), go to LOADF.
  - `ready` is ignored in every other state.
- **LOADF:** 9 cycles, taps 0..8 in raster order, one per cycle.
  - Window tap (r,c) corresponds to pixel (y+r−1, x+c−1).
- **LOADC:** used when x>0.
  - Window columns shift left by one.
  - 3 cycles load taps 2, 5, 8 (the new right column).
- **Out-of-image taps:**
  - pad_mode=0: tap value is 0. `iaddr` is still driven with the clamped address and the cycle is still spent.
  - pad_mode=1: the coordinate is clamped to [0, IMG_W−1] × [0, IMG_H−1] and the tap is read normally.
- **Address arithmetic:** `iaddr` = row_base + col.
  - row_base is maintained incrementally (± IMG_W); no multiplier.
  - All address arithmetic is in AW bits; no wrap-around is permitted.
- **SORT:**
  - The 9 taps are copied into a sort buffer; the window itself is never reordered.
  - 9 cycles of odd-even transposition, one compare-exchange layer per cycle, ascending order.
  - Result index: median → 4, min → 0, max → 8.
  - The cycle count is fixed for all modes.
- **WRITE:** 1 cycle; `wen`=1, `addr` = y·IMG_W + x, `data_wr` = selected value.
  - Then advance raster: x+1. At x=IMG_W−1, x=0 and y+1.
  - Next state: LOADC if the new x>0; LOADF if x=0; DONE after pixel (IMG_W−1, IMG_H−1).
- **DONE:** `done`=1 for 1 cycle, `busy`=0, then IDLE.
- **Ties:** equal values are handled stably; the output value is independent of tie order.

## Timing
- **Reset values:** state IDLE, x=y=0. `busy`, `done`, `wen` = 0; `iaddr`, `addr`, `data_wr` = 0. Sort buffer and window contents are don't-care.
- **`busy`:** rises in the cycle after `ready` is sampled in IDLE. Stays high through the final WRITE. Low in DONE and IDLE.
- **Per-pixel latency:**
  - x=0 pixel: 9 + 9 + 1 = 19 cycles.
  - Other pixels: 3 + 9 + 1 = 13 cycles.
  - Frame: IMG_H·(19 + 13·(IMG_W−1)) cycles. Default 128×128 = 213760 cycles, plus 1 DONE cycle.
- **`wen`:** asserted only in WRITE, for exactly one cycle per pixel. `addr`/`data_wr` are valid in that same cycle and are 0 otherwise.
- **Reset mid-frame:** immediate return to IDLE. No further `wen`; `done` is not pulsed.
- **`ready` held high through DONE:** a new frame starts on the IDLE cycle following DONE.

## Structure
- **Package `mfe_pkg`:** state enum, mode encodings (`MODE_MED`, `MODE_MIN`, `MODE_MAX`), pad encodings, index constants `IDX_MIN`/`IDX_MED`/`IDX_MAX`.
- **Sub-module `oe_sort9`:** registered 9-entry odd-even transposition sorter.
  - Interface: `load`, `step`, 9×DW in, 9×DW out.
  - Layer parity comes from an internal step counter.
- **Top level:** FSM, x/y/row_base counters, tap address/clamp logic, 3×3 window register with column shift.

## Test plan
- **Constant image** (all 0x55), default size, median, pad=0:
  - Interior outputs 0x55; corners 0x00 (5 zeros of 9).
  - Edges 0x55 (6 of 9 are 0x55, so rank 4 is 0x55).
  - `done` at cycle 213760 after start.
- **Same constant image, pad=1:** every output is 0x55, including corners and edges.
- **Ramp image** pixel = (x+y) mod 256, 8×8, min mode, pad=1:
  - Output(x,y) = max(x−1,0) + max(y−1,0).
  - The bench checks all 64 `wen` cycles and their addresses 0..63 in order.
- **Impulse** 0xFF at (3,3) in a 0x00 8×8 image:
  - Max mode: 0xFF at the 9 neighbours (2..4, 2..4) and 0 elsewhere.
  - Median mode: all 0.
- **Reset asserted during pixel 20's SORT:**
  - `wen`, `busy`, `done` go to 0 immediately.
  - A new start rewrites from `addr` 0.
- **mode=11 and `ready` toggled while busy:**
  - Results match median mode.
  - No restart occurs; the frame completes normally.
